// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-select and FSM state definitions for the sequential accumulator CPU.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    OPERAND,
    EXECUTE,
    OUT_WAIT,
    HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_OUT = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JC  = 4'hA;
  localparam logic [3:0] OP_LDA = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  function automatic logic is_two_word(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
  endfunction

endpackage

// File: rtl/seq_cpu_if.sv
// Program-memory fetch port and valid/ready output stream of the sequential CPU core.
interface seq_cpu_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
);
  logic [PC_W-1:0]   imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output imem_addr,
    output out_data,
    output out_valid,
    input  imem_data,
    input  out_ready
  );

  modport slave (
    input  imem_addr,
    input  out_data,
    input  out_valid,
    output imem_data,
    output out_ready
  );
endinterface

// File: rtl/seq_cpu_alu.sv
// Combinational ALU for the accumulator CPU; the extra top bit carries the carry/borrow.
module seq_cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide = '0;
    case (op)
      ALU_ADD: wide = {1'b0, a} + {1'b0, b};
      ALU_SUB: wide = {1'b0, a} - {1'b0, b};
      ALU_AND: wide = {1'b0, a & b};
      default: wide = {1'b0, a | b};
    endcase
    result = wide[DATA_W-1:0];
    zero   = (wide[DATA_W-1:0] == '0);
    carry  = wide[DATA_W];
  end

endmodule

// File: rtl/seq_cpu_core.sv
// Multi-cycle accumulator CPU core: FETCH/DECODE/OPERAND/EXECUTE FSM, register file, flags, OUT stream.
// Optional ILLEGAL_OP_TRAP_EN: opcodes C/D/E halt the core and raise the sticky illegal flag.
module seq_cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PC_W     = 8,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  seq_cpu_if.master         bus,
  output logic              halted,
  output logic              illegal,
  output logic [DATA_W-1:0] acc_dbg
);

  localparam int RSEL_W = $clog2(NUM_REGS);

  state_t state, next_state;

  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              z_flag;
  logic              c_flag;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;

  logic [3:0]        opcode;
  logic [RSEL_W-1:0] rsel;
  logic [1:0]        alu_op;
  logic              alu_en;
  logic              take_branch;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_carry;
  logic              unused_bits;

  assign opcode      = ir[DATA_W-1 -: 4];
  assign rsel        = ir[RSEL_W-1:0];
  assign unused_bits = ^{ir, imm};

  assign bus.imem_addr = pc;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign acc_dbg       = acc;

  seq_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (acc),
    .b      (regs[rsel]),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= next_state;
  end

  always_comb begin
    next_state  = state;
    alu_op      = ALU_ADD;
    alu_en      = 1'b0;
    take_branch = 1'b0;
    case (state)
      FETCH:   next_state = DECODE;
      DECODE:  next_state = is_two_word(opcode) ? OPERAND : EXECUTE;
      OPERAND: next_state = EXECUTE;
      EXECUTE: begin
        next_state = FETCH;
        case (opcode)
          OP_ADD: begin alu_en = 1'b1; alu_op = ALU_ADD; end
          OP_SUB: begin alu_en = 1'b1; alu_op = ALU_SUB; end
          OP_AND: begin alu_en = 1'b1; alu_op = ALU_AND; end
          OP_OR:  begin alu_en = 1'b1; alu_op = ALU_OR;  end
          OP_OUT: next_state = OUT_WAIT;
          OP_JMP: take_branch = 1'b1;
          OP_JZ:  take_branch = z_flag;
          OP_JC:  take_branch = c_flag;
          OP_HLT: next_state = HALT;
`ifdef ILLEGAL_OP_TRAP_EN
          4'hC, 4'hD, 4'hE: next_state = HALT;
`endif
          default: ;
        endcase
      end
      OUT_WAIT: if (bus.out_ready) next_state = FETCH;
      HALT:     next_state = HALT;
      default:  next_state = FETCH;
    endcase
  end

  // Datapath: every register holds unless the current state explicitly updates it,
  // which keeps pc/out_data stable while OUT_WAIT stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= '0;
      ir          <= '0;
      imm         <= '0;
      acc         <= '0;
      z_flag      <= 1'b0;
      c_flag      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          ir <= bus.imem_data;
          pc <= pc + 1'b1;
        end
        OPERAND: begin
          imm <= bus.imem_data;
          pc  <= pc + 1'b1;
        end
        EXECUTE: begin
          if (alu_en) begin
            acc    <= alu_result;
            z_flag <= alu_zero;
            c_flag <= alu_carry;
          end
          if (take_branch) pc <= imm[PC_W-1:0];
          case (opcode)
            OP_LDI: regs[rsel] <= imm;
            OP_MOV: regs[rsel] <= acc;
            OP_LDA: acc <= regs[rsel];
            OP_OUT: begin
              out_data_q  <= acc;
              out_valid_q <= 1'b1;
            end
            default: ;
          endcase
          if (next_state == HALT) halted <= 1'b1;
        end
        OUT_WAIT: if (bus.out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) illegal_q <= 1'b0;
    else if (state == EXECUTE && (opcode == 4'hC || opcode == 4'hD || opcode == 4'hE))
      illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_seq_cpu_core.sv
// Directed-program bench for seq_cpu_core; OUT words are checked against a scoreboard queue.
module tb_seq_cpu_core;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       halted;
  logic       illegal;
  logic [7:0] acc_dbg;
  logic [7:0] mem [256];

  int         vectors = 0;
  int         miscompares = 0;
  int         transfers = 0;
  logic [7:0] sb [$];

  seq_cpu_if #(.DATA_W(8), .PC_W(8)) bus ();

  seq_cpu_core #(.DATA_W(8), .PC_W(8), .NUM_REGS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .halted  (halted),
    .illegal (illegal),
    .acc_dbg (acc_dbg)
  );

  always #5 clk = ~clk;

  assign bus.imem_data = mem[bus.imem_addr];

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Each accepted output word must match the oldest expected word.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      transfers++;
      if (sb.size() == 0) check_output("sb_underflow", 32'(sb.size()), 32'd1);
      else                check_output("out_word", 32'(bus.out_data), 32'(sb.pop_front()));
    end
  end

  task automatic apply_stimulus(input logic [7:0] base, input logic [7:0] words [$]);
    for (int i = 0; i < words.size(); i++) mem[8'(int'(base) + i)] = words[i];
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_output({tag, "_rst_addr"}, 32'(bus.imem_addr), 32'h0);
    check_output({tag, "_rst_valid"}, 32'(bus.out_valid), 32'h0);
    check_output({tag, "_rst_halted"}, 32'(halted), 32'h0);
    reset_n = 1'b1;
  endtask

  task automatic run_until_halted(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && !halted; i++) @(negedge clk);
    check_output({tag, "_halted"}, 32'(halted), 32'h1);
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && !bus.out_valid; i++) @(negedge clk);
    check_output({tag, "_valid_seen"}, 32'(bus.out_valid), 32'h1);
  endtask

  initial begin
    logic [7:0] prog [$];
    int         t0;
    int         hi_cycles;
    bus.out_ready = 1'b1;

    // Test 1: LDI R0,5; ADD R0; OUT; HLT.
    clear_mem();
    prog = {8'h10, 8'h05, 8'h20, 8'h70, 8'hF0};
    apply_stimulus(8'h00, prog);
    sb.push_back(8'h05);
    t0 = transfers;
    do_reset("t1");
    check_output("t1_rst_acc", 32'(acc_dbg), 32'h0);
    check_output("t1_rst_illegal", 32'(illegal), 32'h0);
    hi_cycles = 0;
    for (int i = 0; i < 100 && !halted; i++) begin
      @(negedge clk);
      if (bus.out_valid) hi_cycles++;
    end
    check_output("t1_halted", 32'(halted), 32'h1);
    check_output("t1_valid_cycles", 32'(hi_cycles), 32'd1);
    repeat (10) @(negedge clk);
    check_output("t1_valid_after", 32'(bus.out_valid), 32'h0);
    check_output("t1_acc", 32'(acc_dbg), 32'h05);
    check_output("t1_transfers", 32'(transfers - t0), 32'd1);
    check_output("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Test 2: 3-5 borrows, JC taken to 0x20; JZ there must fall through.
    clear_mem();
    prog = {8'h11, 8'h03, 8'h21, 8'h12, 8'h05, 8'h32, 8'hA0, 8'h20};
    apply_stimulus(8'h00, prog);
    prog = {8'h70, 8'h90, 8'h30, 8'hF0};
    apply_stimulus(8'h20, prog);
    sb.push_back(8'hFE);
    do_reset("t2");
    run_until_halted("t2", 200);
    check_output("t2_acc", 32'(acc_dbg), 32'hFE);
    check_output("t2_pc", 32'(bus.imem_addr), 32'h24);
    check_output("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Test 3: 5-5 sets Z, JZ 0x40 taken; JC not taken; ADD clears Z; JZ falls through to +2.
    clear_mem();
    prog = {8'h10, 8'h05, 8'h20, 8'h30, 8'h70, 8'h90, 8'h40};
    apply_stimulus(8'h00, prog);
    prog = {8'hA0, 8'h50, 8'h20, 8'h90, 8'h60, 8'h70, 8'hF0};
    apply_stimulus(8'h40, prog);
    sb.push_back(8'h00);
    sb.push_back(8'h05);
    do_reset("t3");
    run_until_halted("t3", 300);
    check_output("t3_acc", 32'(acc_dbg), 32'h05);
    check_output("t3_pc", 32'(bus.imem_addr), 32'h47);
    check_output("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Test 4: OUT stalls five cycles with the sink not ready.
    clear_mem();
    prog = {8'h10, 8'hAB, 8'h20, 8'h70, 8'hF0};
    apply_stimulus(8'h00, prog);
    sb.push_back(8'hAB);
    bus.out_ready = 1'b0;
    t0 = transfers;
    do_reset("t4");
    wait_valid("t4", 50);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("t4_stall_valid", 32'(bus.out_valid), 32'h1);
      check_output("t4_stall_data", 32'(bus.out_data), 32'hAB);
      check_output("t4_stall_pc", 32'(bus.imem_addr), 32'h04);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("t4_valid_drop", 32'(bus.out_valid), 32'h0);
    run_until_halted("t4", 50);
    check_output("t4_transfers", 32'(transfers - t0), 32'd1);
    check_output("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Test 5: reset asserted while a word is pending drops it and restarts at 0x00.
    bus.out_ready = 1'b0;
    do_reset("t5");
    wait_valid("t5", 50);
    #2 reset_n = 1'b0;
    #1;
    check_output("t5_async_valid", 32'(bus.out_valid), 32'h0);
    check_output("t5_async_pc", 32'(bus.imem_addr), 32'h0);
    check_output("t5_async_acc", 32'(acc_dbg), 32'h0);
    sb.push_back(8'hAB);
    bus.out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    check_output("t5_refetch_addr", 32'(bus.imem_addr), 32'h0);
    @(negedge clk);
    check_output("t5_pc_after_fetch", 32'(bus.imem_addr), 32'h1);
    run_until_halted("t5", 50);
    check_output("t5_sb_empty", 32'(sb.size()), 32'd0);

    // Test 6: opcode C0, then JMP 0xFF with NOP there wrapping pc to 0x00.
    clear_mem();
    prog = {8'h90, 8'h10, 8'hC0, 8'h10, 8'h07, 8'h20, 8'h70, 8'h30, 8'h80, 8'hFF};
    apply_stimulus(8'h00, prog);
    mem[8'hFF] = 8'h00;
`ifdef ILLEGAL_OP_TRAP_EN
    do_reset("t6");
    run_until_halted("t6", 200);
    check_output("t6_illegal", 32'(illegal), 32'h1);
    check_output("t6_pc", 32'(bus.imem_addr), 32'h03);
    check_output("t6_acc", 32'(acc_dbg), 32'h00);
`else
    sb.push_back(8'h07);
    do_reset("t6");
    run_until_halted("t6", 300);
    check_output("t6_illegal", 32'(illegal), 32'h0);
    check_output("t6_pc", 32'(bus.imem_addr), 32'h11);
    check_output("t6_acc", 32'(acc_dbg), 32'h00);
`endif
    check_output("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
